// File: rtl/dir_access_ctrl.sv
// Purpose : coherence sequencer in front of the directory: lookup, optional probe, directory write, grant.
// Latency : accept at T -> LOOKUP T+1, UPDATE T+2, grant_valid T+3 (no probe); with a probe, PROBE begins at T+2.
// Backpr. : req_ready only in IDLE; probe and grant outputs held stable until their ready; one transaction in flight.
// Ports   : req_* (request in), lookup_* (combinational directory read), update_* (directory write strobe),
//           probe_* / probe_ack_* (probe out, ack in), grant_* (grant out), busy, timeout_err.
// Build   : define DAC_TIMEOUT_EN to enable the probe-ack watchdog (ACK_TIMEOUT cycles, sticky timeout_err).
module dir_access_ctrl #(
  parameter int ADDR_W      = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_src,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_perm,
  output logic              lookup_req,
  output logic [ADDR_W-1:0] lookup_addr,
  input  logic [2:0]        lookup_state,
  input  logic [1:0]        lookup_presence,
  input  logic [1:0]        lookup_tip_state,
  output logic              update_req,
  output logic [ADDR_W-1:0] update_addr,
  output logic [2:0]        update_state,
  output logic [1:0]        update_presence,
  output logic [1:0]        update_tip_state,
  output logic              probe_valid,
  input  logic              probe_ready,
  output logic              probe_dst,
  output logic [ADDR_W-1:0] probe_addr,
  output logic              probe_cap,
  input  logic              probe_ack_valid,
  input  logic              probe_ack_src,
  output logic              grant_valid,
  input  logic              grant_ready,
  output logic              grant_dst,
  output logic              grant_perm,
  output logic              busy,
  output logic              timeout_err
);

  // Directory state encodings shared with the directory (tidc_params.v).
  localparam logic [2:0] DIR_STATE_SHARED    = 3'd1;
  localparam logic [2:0] DIR_STATE_EXCLUSIVE = 3'd2;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_PROBE    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_UPDATE   = 3'd4;
  localparam logic [2:0] S_GRANT    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              src_q, src_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              perm_q, perm_d;
  logic [1:0]        pres_q, pres_d;
  logic              cap_q, cap_d;
  logic              other;
  logic              ack_hit;
  logic              to_hit;
  logic              upd_excl;
  logic [1:0]        src_onehot;

  assign other      = ~src_q;
  assign ack_hit    = probe_ack_valid && (probe_ack_src == other);
  assign src_onehot = src_q ? 2'b10 : 2'b01;
  // A read only ends up SHARED when the other agent keeps a copy (downgraded or already Branch).
  assign upd_excl   = perm_q || !pres_q[other];

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    addr_d  = addr_q;
    perm_d  = perm_q;
    pres_d  = pres_q;
    cap_d   = cap_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          src_d   = req_src;
          addr_d  = req_addr;
          perm_d  = req_perm;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        pres_d  = lookup_presence;
        state_d = S_UPDATE;
        // Only the other agent is ever probed; the requester's own copy never needs one.
        if (perm_q && lookup_presence[other]) begin
          cap_d   = 1'b0;
          state_d = S_PROBE;
        end else if (!perm_q && lookup_tip_state[other]) begin
          cap_d   = 1'b1;
          state_d = S_PROBE;
        end
      end
      S_PROBE:    if (probe_ready) state_d = S_WAIT_ACK;
      S_WAIT_ACK: if (ack_hit || to_hit) state_d = S_UPDATE;
      S_UPDATE:   state_d = S_GRANT;
      S_GRANT:    if (grant_ready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      src_q   <= 1'b0;
      addr_q  <= '0;
      perm_q  <= 1'b0;
      pres_q  <= 2'b00;
      cap_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      perm_q  <= perm_d;
      pres_q  <= pres_d;
      cap_q   <= cap_d;
    end
  end

`ifdef DAC_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);
  logic [7:0] cnt_q;
  logic       terr_q;

  // Counter reads 0 in the first WAIT_ACK cycle, so the limit hits in cycle ACK_TIMEOUT.
  assign to_hit = (state_q == S_WAIT_ACK) && (cnt_q == TO_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 8'd0;
      terr_q <= 1'b0;
    end else begin
      if (state_q == S_PROBE)         cnt_q <= 8'd0;
      else if (state_q == S_WAIT_ACK) cnt_q <= cnt_q + 8'd1;
      if (to_hit) terr_q <= 1'b1;
    end
  end

  assign timeout_err = terr_q;
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^ACK_TIMEOUT;
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // The old directory state is implied by the presence/Tip vectors.
  logic unused_lookup_state;
  assign unused_lookup_state = ^lookup_state;

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);

  assign lookup_req  = (state_q == S_LOOKUP);
  assign lookup_addr = lookup_req ? addr_q : '0;

  assign probe_valid = (state_q == S_PROBE);
  assign probe_dst   = probe_valid & other;
  assign probe_cap   = probe_valid & cap_q;
  assign probe_addr  = probe_valid ? addr_q : '0;

  assign update_req       = (state_q == S_UPDATE);
  assign update_addr      = update_req ? addr_q : '0;
  assign update_state     = !update_req ? 3'd0 : (upd_excl ? DIR_STATE_EXCLUSIVE : DIR_STATE_SHARED);
  assign update_presence  = !update_req ? 2'b00 : (upd_excl ? src_onehot : (pres_q | src_onehot));
  assign update_tip_state = (update_req && upd_excl) ? src_onehot : 2'b00;

  assign grant_valid = (state_q == S_GRANT);
  assign grant_dst   = grant_valid & src_q;
  assign grant_perm  = grant_valid & upd_excl;

endmodule

// File: tb/tb_dir_access_ctrl.sv
// Purpose : directed, table-driven bench for dir_access_ctrl with hand-written multi-cycle corner sequences.
// Latency : checks exact cycle positions of LOOKUP/PROBE/UPDATE/GRANT relative to request acceptance.
// Backpr. : exercises late probe_ready, stray acks, held-off grant_ready, pending request, mid-flight reset.
module tb_dir_access_ctrl;

  localparam logic [2:0] ST_INV  = 3'd0;
  localparam logic [2:0] ST_SHR  = 3'd1;
  localparam logic [2:0] ST_EXCL = 3'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_src = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_perm = 1'b0;
  logic        lookup_req;
  logic [63:0] lookup_addr;
  logic [2:0]  lk_state = '0;
  logic [1:0]  lk_pres = '0;
  logic [1:0]  lk_tip = '0;
  logic        update_req;
  logic [63:0] update_addr;
  logic [2:0]  update_state;
  logic [1:0]  update_presence;
  logic [1:0]  update_tip_state;
  logic        probe_valid;
  logic        probe_ready = 1'b0;
  logic        probe_dst;
  logic [63:0] probe_addr;
  logic        probe_cap;
  logic        probe_ack_valid = 1'b0;
  logic        probe_ack_src = 1'b0;
  logic        grant_valid;
  logic        grant_ready = 1'b0;
  logic        grant_dst;
  logic        grant_perm;
  logic        busy;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dir_access_ctrl #(.ADDR_W(64), .ACK_TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
    .req_addr(req_addr), .req_perm(req_perm),
    .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_state(lk_state),
    .lookup_presence(lk_pres), .lookup_tip_state(lk_tip),
    .update_req(update_req), .update_addr(update_addr), .update_state(update_state),
    .update_presence(update_presence), .update_tip_state(update_tip_state),
    .probe_valid(probe_valid), .probe_ready(probe_ready), .probe_dst(probe_dst),
    .probe_addr(probe_addr), .probe_cap(probe_cap),
    .probe_ack_valid(probe_ack_valid), .probe_ack_src(probe_ack_src),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_dst(grant_dst),
    .grant_perm(grant_perm), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    logic        src;
    logic [63:0] addr;
    logic        perm;
    logic [2:0]  l_state;
    logic [1:0]  l_pres;
    logic [1:0]  l_tip;
    logic        exp_probe;
    logic        exp_dst;
    logic        exp_cap;
    int          pr_dly;
    logic        stray;
    logic [2:0]  e_state;
    logic [1:0]  e_pres;
    logic [1:0]  e_tip;
    logic        e_gperm;
    int          gr_dly;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Full transaction; all driving and sampling on the falling edge.
  task automatic run_txn(input vec_t v, input bit pend);
    lk_state  = v.l_state;
    lk_pres   = v.l_pres;
    lk_tip    = v.l_tip;
    req_src   = v.src;
    req_addr  = v.addr;
    req_perm  = v.perm;
    req_valid = 1'b1;
    chk("idle_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("lookup_req", lookup_req, 1);
    chk("lookup_addr", lookup_addr, v.addr);
    chk("busy_lookup", busy, 1);
    chk("req_ready_lookup", req_ready, 0);
    @(negedge clk);
    if (v.exp_probe) begin
      for (int i = 0; i <= v.pr_dly; i++) begin
        chk("probe_out", {probe_valid, probe_dst, probe_cap}, {1'b1, v.exp_dst, v.exp_cap});
        chk("probe_addr", probe_addr, v.addr);
        chk("probe_no_update", update_req, 0);
        if (i == v.pr_dly) probe_ready = 1'b1;
        @(negedge clk);
      end
      probe_ready = 1'b0;
      chk("wait_ack_probe_low", probe_valid, 0);
      chk("wait_ack_no_update", update_req, 0);
      if (v.stray) begin
        probe_ack_valid = 1'b1;
        probe_ack_src   = ~v.exp_dst;
        @(negedge clk);
        probe_ack_valid = 1'b0;
        chk("stray_ack_ignored", update_req, 0);
        chk("stray_ack_busy", busy, 1);
      end
      probe_ack_valid = 1'b1;
      probe_ack_src   = v.exp_dst;
      @(negedge clk);
      probe_ack_valid = 1'b0;
    end else begin
      chk("no_probe", probe_valid, 0);
    end
    chk("update_req", update_req, 1);
    chk("update_addr", update_addr, v.addr);
    chk("update_state", update_state, v.e_state);
    chk("update_presence", update_presence, v.e_pres);
    chk("update_tip", update_tip_state, v.e_tip);
    chk("grant_early", grant_valid, 0);
    @(negedge clk);
    chk("update_one_cycle", update_req, 0);
    for (int i = 0; i <= v.gr_dly; i++) begin
      chk("grant_out", {grant_valid, grant_dst, grant_perm}, {1'b1, v.src, v.e_gperm});
      chk("req_ready_grant", req_ready, 0);
      if (pend && i == 0) begin
        req_valid = 1'b1;
        req_src   = 1'b1;
        req_addr  = 64'h200;
        req_perm  = 1'b0;
      end
      if (i == v.gr_dly) grant_ready = 1'b1;
      @(negedge clk);
    end
    grant_ready = 1'b0;
    chk("grant_done", grant_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("busy_idle", busy, 0);
  endtask

  // Request that needs a probe, driven through the probe handshake into WAIT_ACK.
  task automatic enter_wait_ack(input logic [63:0] a);
    lk_state  = ST_SHR;
    lk_pres   = 2'b11;
    lk_tip    = 2'b00;
    req_src   = 1'b0;
    req_addr  = a;
    req_perm  = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("wa_probe_valid", probe_valid, 1);
    probe_ready = 1'b1;
    @(negedge clk);
    probe_ready = 1'b0;
  endtask

  initial begin
    //          src  addr                    perm l_state  pres   tip    prb  dst  cap  pdly stray e_state  e_pres e_tip gp   gdly
    vecs[0] = '{1'b0, 64'h40,                1'b0, ST_INV,  2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_EXCL, 2'b01, 2'b01, 1'b1, 0};
    vecs[1] = '{1'b1, 64'h40,                1'b0, ST_EXCL, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 2, 1'b0, ST_SHR,  2'b11, 2'b00, 1'b0, 0};
    vecs[2] = '{1'b0, 64'h80,                1'b1, ST_SHR,  2'b11, 2'b00, 1'b1, 1'b1, 1'b0, 0, 1'b1, ST_EXCL, 2'b01, 2'b01, 1'b1, 0};
    vecs[3] = '{1'b0, 64'hC0,                1'b0, ST_SHR,  2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_SHR,  2'b11, 2'b00, 1'b0, 0};
    vecs[4] = '{1'b1, 64'h100,               1'b0, ST_EXCL, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_EXCL, 2'b10, 2'b10, 1'b1, 1};
    vecs[5] = '{1'b1, 64'h140,               1'b1, ST_EXCL, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_EXCL, 2'b10, 2'b10, 1'b1, 0};
    vecs[6] = '{1'b1, 64'hFFFF_0000_0000_1180, 1'b1, ST_SHR, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 1, 1'b0, ST_EXCL, 2'b10, 2'b10, 1'b1, 2};
    vecs[7] = '{1'b0, 64'h1C0,               1'b1, ST_EXCL, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_EXCL, 2'b01, 2'b01, 1'b1, 0};

    // Reset state, both while held and after release.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("por_req_ready", req_ready, 1);
    chk("por_busy", busy, 0);
    chk("por_lookup", {lookup_req, lookup_addr}, 0);
    chk("por_update", {update_req, update_state, update_presence, update_tip_state}, 0);
    chk("por_update_addr", update_addr, 0);
    chk("por_probe", {probe_valid, probe_dst, probe_cap}, 0);
    chk("por_probe_addr", probe_addr, 0);
    chk("por_grant", {grant_valid, grant_dst, grant_perm}, 0);
    chk("por_timeout_err", timeout_err, 0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i], 1'b0);

    // grant_ready held low 5 cycles while a second request waits.
    begin
      vec_t g;
      g = '{1'b0, 64'h240, 1'b0, ST_INV, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0, 1'b0, ST_EXCL, 2'b01, 2'b01, 1'b1, 5};
      run_txn(g, 1'b1);
    end
    lk_state = ST_INV;
    lk_pres  = 2'b00;
    lk_tip   = 2'b00;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pend_lookup_req", lookup_req, 1);
    chk("pend_lookup_addr", lookup_addr, 64'h200);
    @(negedge clk);
    chk("pend_update", {update_req, update_state, update_presence, update_tip_state},
        {1'b1, ST_EXCL, 2'b10, 2'b10});
    @(negedge clk);
    chk("pend_grant", {grant_valid, grant_dst, grant_perm}, 3'b111);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    chk("pend_idle", busy, 0);

`ifdef DAC_TIMEOUT_EN
    // Ack never arrives: watchdog fires after 10 WAIT_ACK cycles.
    enter_wait_ack(64'h300);
    for (int k = 1; k <= 10; k++) begin
      chk("to_no_update", update_req, 0);
      chk("to_err_early", timeout_err, 0);
      @(negedge clk);
    end
    chk("to_update", update_req, 1);
    chk("to_err_set", timeout_err, 1);
    chk("to_update_entry", {update_state, update_presence, update_tip_state}, {ST_EXCL, 2'b01, 2'b01});
    @(negedge clk);
    chk("to_grant", {grant_valid, grant_dst, grant_perm}, 3'b101);
    grant_ready = 1'b1;
    @(negedge clk);
    grant_ready = 1'b0;
    chk("to_err_sticky", timeout_err, 1);
    chk("to_idle", busy, 0);
    rst = 1'b1;
    #1;
    chk("to_err_cleared", timeout_err, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`endif

    // Reset while waiting for an ack aborts with no directory write.
    enter_wait_ack(64'h400);
    begin
      int wcyc;
`ifdef DAC_TIMEOUT_EN
      wcyc = 5;
`else
      wcyc = 20;
`endif
      for (int k = 0; k < wcyc; k++) begin
        chk("wa_hold_no_update", update_req, 0);
        chk("wa_hold_busy", busy, 1);
        chk("wa_hold_no_err", timeout_err, 0);
        @(negedge clk);
      end
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_idle", busy, 0);
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_no_update", update_req, 0);
    @(negedge clk);
    chk("mid_rst_held_no_update", update_req, 0);
    rst = 1'b0;
    probe_ack_valid = 1'b1;
    probe_ack_src   = 1'b1;
    @(negedge clk);
    probe_ack_valid = 1'b0;
    chk("post_rst_no_update", update_req, 0);
    chk("post_rst_idle", busy, 0);
    @(negedge clk);
    chk("post_rst_no_grant", grant_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
